// File: rtl/add_node_conn.sv
// Streaming NEAT add-node mutation: passes node genes while tracking the highest ID, and
// splits selected connection genes into disabled original + new hidden node + two new links.
module add_node_conn #(
  parameter int                  GENE_SZ      = 64,
  parameter int                  ATTR_SZ      = 8,
  parameter int                  LIM_ADD_NODE = 4,
  parameter logic [ATTR_SZ-1:0]  UNIT_WEIGHT  = 8'h40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               setup_i,
  input  logic               state_i,
  input  logic [ATTR_SZ-1:0] node_add_prob_i,
  input  logic [ATTR_SZ-1:0] random_i,
  input  logic [GENE_SZ-1:0] gene_in_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [GENE_SZ-1:0] gene_out_o,
  output logic               out_is_node_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  localparam int CTR_W = $clog2(LIM_ADD_NODE + 1);
  localparam logic [CTR_W-1:0] LIM = CTR_W'(LIM_ADD_NODE);

  typedef enum logic [1:0] {PASS, S_NODE, S_C1, S_C2} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [ATTR_SZ-1:0] prob_q;
  logic [ATTR_SZ-1:0] max_id_q, max_id_d;
  logic [ATTR_SZ-1:0] new_id_q, new_id_d;
  logic [CTR_W-1:0]   add_ctr_q, add_ctr_d;
  logic [GENE_SZ-1:0] hold_q, hold_d;
  logic [GENE_SZ-1:0] gene_out_q, gene_out_d;
  logic               is_node_q, is_node_d;
  logic               valid_q, valid_d;

  logic slot_free;
  logic accept;
  logic split;

  assign slot_free     = !valid_q || out_ready_i;
  assign in_ready_o    = (fsm_q == PASS) && slot_free && !setup_i;
  assign accept        = in_valid_i && in_ready_o;
  assign split         = gene_in_i[55] && (random_i > prob_q) && (add_ctr_q < LIM) &&
                         (max_id_q != {ATTR_SZ{1'b1}});
  assign gene_out_o    = gene_out_q;
  assign out_is_node_o = is_node_q;
  assign out_valid_o   = valid_q;

  always_comb begin
    fsm_d      = fsm_q;
    max_id_d   = max_id_q;
    new_id_d   = new_id_q;
    add_ctr_d  = add_ctr_q;
    hold_d     = hold_q;
    gene_out_d = gene_out_q;
    is_node_d  = is_node_q;
    valid_d    = valid_q;
    case (fsm_q)
      PASS: begin
        if (accept) begin
          valid_d    = 1'b1;
          gene_out_d = gene_in_i;
          is_node_d  = !state_i;
          if (!state_i) begin
            if (gene_in_i[47:40] > max_id_q) max_id_d = gene_in_i[47:40];
          end else if (split) begin
            gene_out_d[55] = 1'b0;
            hold_d         = gene_in_i;
            new_id_d       = max_id_q + 8'd1;
            fsm_d          = S_NODE;
          end
        end else if (out_ready_i) begin
          valid_d = 1'b0;
        end
      end
      S_NODE: begin
        if (slot_free) begin
          gene_out_d        = '0;
          gene_out_d[47:40] = new_id_q;
          is_node_d         = 1'b1;
          valid_d           = 1'b1;
          fsm_d             = S_C1;
        end
      end
      S_C1: begin
        if (slot_free) begin
          gene_out_d        = hold_q;
          gene_out_d[55]    = 1'b1;
          gene_out_d[39:32] = new_id_q;
          gene_out_d[31:24] = UNIT_WEIGHT;
          is_node_d         = 1'b0;
          valid_d           = 1'b1;
          fsm_d             = S_C2;
        end
      end
      S_C2: begin
        if (slot_free) begin
          gene_out_d        = hold_q;
          gene_out_d[55]    = 1'b1;
          gene_out_d[47:40] = new_id_q;
          is_node_d         = 1'b0;
          valid_d           = 1'b1;
          max_id_d          = new_id_q;
          add_ctr_d         = add_ctr_q + CTR_W'(1);
          fsm_d             = PASS;
        end
      end
      default: fsm_d = PASS;
    endcase
    // setup aborts any split in flight and wins over a same-cycle accept
    if (setup_i) begin
      fsm_d      = PASS;
      max_id_d   = '0;
      new_id_d   = '0;
      add_ctr_d  = '0;
      hold_d     = '0;
      gene_out_d = '0;
      is_node_d  = 1'b0;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= PASS;
      max_id_q   <= '0;
      new_id_q   <= '0;
      add_ctr_q  <= '0;
      hold_q     <= '0;
      gene_out_q <= '0;
      is_node_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      max_id_q   <= max_id_d;
      new_id_q   <= new_id_d;
      add_ctr_q  <= add_ctr_d;
      hold_q     <= hold_d;
      gene_out_q <= gene_out_d;
      is_node_q  <= is_node_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prob_q <= '0;
    else if (setup_i) prob_q <= node_add_prob_i;
  end

endmodule

// File: tb/tb_add_node_conn.sv
// Scoreboard bench for add_node_conn: stimulus pushes expected genes, a negedge monitor
// pops and compares every output beat taken by the downstream side.
module tb_add_node_conn;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        setup = 1'b0;
  logic        state = 1'b0;
  logic [7:0]  prob = 8'h00;
  logic [7:0]  random = 8'h00;
  logic [63:0] gene_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] gene_out;
  logic        out_is_node;
  logic        out_valid;
  logic        out_ready = 1'b1;

  typedef struct packed {
    logic [63:0] gene;
    logic        isNode;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  logic bpMode = 1'b0;

  add_node_conn dut (
    .clk(clk), .rst(rst), .setup_i(setup), .state_i(state),
    .node_add_prob_i(prob), .random_i(random), .gene_in_i(gene_in),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .gene_out_o(gene_out),
    .out_is_node_o(out_is_node), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkNode(input logic [7:0] id);
    return {8'h00, 1'b0, 2'b01, 5'b0, id, 16'h0000, 24'h123456};
  endfunction

  function automatic logic [63:0] mkConn(input logic en, input logic [7:0] src,
                                         input logic [7:0] dst, input logic [7:0] w);
    return {8'hC3, en, 2'b00, 5'b0, src, dst, w, 24'h0F0F0F};
  endfunction

  function automatic logic [63:0] newNode(input logic [7:0] id);
    return {16'h0000, id, 40'h0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [63:0] g, input logic n);
    exp_t e;
    e.gene   = g;
    e.isNode = n;
    expQ.push_back(e);
  endtask

  // Holds gene_in valid until the DUT accepts it; returns just after the accepting edge.
  task automatic applyStimulus(input logic [63:0] g, input logic st, input logic [7:0] rnd);
    int   n = 0;
    logic got;
    gene_in  = g;
    state    = st;
    random   = rnd;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 200);
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected accept within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic doSetup(input logic [7:0] p);
    setup    = 1'b1;
    prob     = p;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("setup_blocks_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    setup    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic splitExp(input logic [63:0] conn, input logic [7:0] newId);
    logic [63:0] g;
    g = conn; g[55] = 1'b0;
    pushExp(g, 1'b0);
    pushExp(newNode(newId), 1'b1);
    g = conn; g[55] = 1'b1; g[39:32] = newId; g[31:24] = 8'h40;
    pushExp(g, 1'b0);
    g = conn; g[55] = 1'b1; g[47:40] = newId;
    pushExp(g, 1'b0);
  endtask

  // Downstream ready: always 1, or the 1,0,0,1 pattern in backpressure mode.
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bpMode) begin
        out_ready = pat[k];
        k = (k + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: one pop per taken beat, plus stability checks across stalls.
  initial begin
    exp_t        e;
    logic        stalled;
    logic [63:0] stallGene;
    logic        stallNode;
    stalled = 1'b0;
    stallGene = '0;
    stallNode = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stall_valid", {63'b0, out_valid}, 64'd1);
          checkOutput("stall_gene", gene_out, stallGene);
          checkOutput("stall_is_node", {63'b0, out_is_node}, {63'b0, stallNode});
        end
        stalled   = out_valid && !out_ready;
        stallGene = gene_out;
        stallNode = out_is_node;
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_beat: got %h expected no output", gene_out);
          end else begin
            e = expQ.pop_front();
            checkOutput("beat_gene", gene_out, e.gene);
            checkOutput("beat_is_node", {63'b0, out_is_node}, {63'b0, e.isNode});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] pass-through");
    doSetup(8'hFF);
    pushExp(mkNode(8'd1), 1'b1);
    applyStimulus(mkNode(8'd1), 1'b0, 8'h00);
    checkOutput("latency_valid", {63'b0, out_valid}, 64'd1);
    checkOutput("latency_gene", gene_out, mkNode(8'd1));
    pushExp(mkNode(8'd2), 1'b1);
    applyStimulus(mkNode(8'd2), 1'b0, 8'h00);
    pushExp(mkNode(8'd5), 1'b1);
    applyStimulus(mkNode(8'd5), 1'b0, 8'h00);
    pushExp(mkConn(1'b1, 8'd1, 8'd2, 8'h11), 1'b0);
    applyStimulus(mkConn(1'b1, 8'd1, 8'd2, 8'h11), 1'b1, 8'hFF);
    pushExp(mkConn(1'b1, 8'd2, 8'd5, 8'h22), 1'b0);
    applyStimulus(mkConn(1'b1, 8'd2, 8'd5, 8'h22), 1'b1, 8'hFF);
    drain();

    $display("[TB] single split");
    doSetup(8'h00);
    for (int i = 1; i <= 3; i++) begin
      pushExp(mkNode(8'(i)), 1'b1);
      applyStimulus(mkNode(8'(i)), 1'b0, 8'h00);
    end
    pushExp(64'h5A00_0103_20AB_CDEF, 1'b0);
    pushExp(64'h0000_0400_0000_0000, 1'b1);
    pushExp(64'h5A80_0104_40AB_CDEF, 1'b0);
    pushExp(64'h5A80_0403_20AB_CDEF, 1'b0);
    applyStimulus(64'h5A80_0103_20AB_CDEF, 1'b1, 8'h80);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("split_ready_low", {63'b0, in_ready}, 64'd0);
    end
    @(negedge clk);
    checkOutput("split_ready_back", {63'b0, in_ready}, 64'd1);
    drain();

    $display("[TB] limit");
    doSetup(8'h00);
    for (int i = 1; i <= 3; i++) begin
      pushExp(mkNode(8'(i)), 1'b1);
      applyStimulus(mkNode(8'(i)), 1'b0, 8'h00);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) splitExp(mkConn(1'b1, 8'd1, 8'd3, 8'(8'h10 + i)), 8'(4 + i));
      else       pushExp(mkConn(1'b1, 8'd1, 8'd3, 8'(8'h10 + i)), 1'b0);
      applyStimulus(mkConn(1'b1, 8'd1, 8'd3, 8'(8'h10 + i)), 1'b1, 8'h80);
    end
    drain();

    $display("[TB] backpressure");
    doSetup(8'h00);
    bpMode = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      pushExp(mkNode(8'(i)), 1'b1);
      applyStimulus(mkNode(8'(i)), 1'b0, 8'h00);
    end
    pushExp(64'h5A00_0103_20AB_CDEF, 1'b0);
    pushExp(64'h0000_0400_0000_0000, 1'b1);
    pushExp(64'h5A80_0104_40AB_CDEF, 1'b0);
    pushExp(64'h5A80_0403_20AB_CDEF, 1'b0);
    applyStimulus(64'h5A80_0103_20AB_CDEF, 1'b1, 8'h80);
    pushExp(mkConn(1'b0, 8'd2, 8'd3, 8'h33), 1'b0);
    applyStimulus(mkConn(1'b0, 8'd2, 8'd3, 8'h33), 1'b1, 8'h80);
    drain();
    bpMode = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] abort");
    doSetup(8'h00);
    for (int i = 1; i <= 3; i++) begin
      pushExp(mkNode(8'(i)), 1'b1);
      applyStimulus(mkNode(8'(i)), 1'b0, 8'h00);
    end
    drain();
    pushExp(64'h5A00_0103_20AB_CDEF, 1'b0);
    pushExp(64'h0000_0400_0000_0000, 1'b1);
    applyStimulus(64'h5A80_0103_20AB_CDEF, 1'b1, 8'h80);
    @(posedge clk);
    #1;
    setup = 1'b1;
    prob  = 8'h00;
    @(posedge clk);
    #1;
    setup = 1'b0;
    @(negedge clk);
    checkOutput("abort_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("abort_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("abort_queue_left", 64'(expQ.size()), 64'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    pushExp(mkNode(8'd1), 1'b1);
    applyStimulus(mkNode(8'd1), 1'b0, 8'h00);
    splitExp(mkConn(1'b1, 8'd1, 8'd1, 8'h55), 8'd2);
    applyStimulus(mkConn(1'b1, 8'd1, 8'd1, 8'h55), 1'b1, 8'h80);
    drain();

    $display("[TB] disabled and saturated");
    doSetup(8'h00);
    pushExp(mkConn(1'b0, 8'd7, 8'd9, 8'h66), 1'b0);
    applyStimulus(mkConn(1'b0, 8'd7, 8'd9, 8'h66), 1'b1, 8'h80);
    pushExp(mkNode(8'hFF), 1'b1);
    applyStimulus(mkNode(8'hFF), 1'b0, 8'h00);
    pushExp(mkConn(1'b1, 8'd7, 8'hFF, 8'h77), 1'b0);
    applyStimulus(mkConn(1'b1, 8'd7, 8'hFF, 8'h77), 1'b1, 8'hF0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
